// File: rtl/rv32i_storeunit.sv
// Memory-stage store unit: formats SB/SH/SW into byte lanes and queues them in a
// small in-order store buffer draining over valid/ready. Optional macro: MISALIGN_TRAP_EN.
module rv32i_storeunit #(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          MemWriteM,
   input  logic [2:0]    StoreSizeM,
   input  logic [AW-1:0] ALUResultM,
   input  logic [31:0]   WriteDataM,
   output logic          StallStore,
   output logic          SBEmpty,
`ifdef MISALIGN_TRAP_EN
   output logic          MisalignedM,
`endif
   output logic          DMemWE,
   output logic [AW-1:0] DMemAddr,
   output logic [31:0]   DMemWData,
   output logic [3:0]    DMemBE,
   input  logic          DMemReady
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg, count_next;

   logic [AW-1:0] addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [3:0]    be_mem   [DEPTH];

   logic [1:0]  a;
   logic        size_ok;
   logic        size_sh, size_sw;
   logic [31:0] fmt_data;
   logic [3:0]  fmt_be;
   logic        mis;
   logic        req, full, enq, deq;

   assign a = ALUResultM[1:0];

   always_comb begin
      size_ok  = 1'b0;
      size_sh  = 1'b0;
      size_sw  = 1'b0;
      fmt_data = '0;
      fmt_be   = '0;
      case (StoreSizeM)
         3'b000: begin
            size_ok  = 1'b1;
            fmt_data = {4{WriteDataM[7:0]}};
            fmt_be   = 4'b0001 << a;
         end
         3'b001: begin
            size_ok  = 1'b1;
            size_sh  = 1'b1;
            fmt_data = {2{WriteDataM[15:0]}};
            fmt_be   = a[1] ? 4'b1100 : 4'b0011;
         end
         3'b010: begin
            size_ok  = 1'b1;
            size_sw  = 1'b1;
            fmt_data = WriteDataM;
            fmt_be   = 4'b1111;
         end
         default: ;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign mis         = MemWriteM & ((size_sh & a[0]) | (size_sw & (a != 2'b00)));
   assign MisalignedM = mis;
`else
   // Without the trap, misaligned halves/words are silently aligned down.
   assign mis = 1'b0 & size_sh & size_sw;
`endif

   // A stalled request is simply retried each cycle; a same-cycle dequeue does not relieve it.
   assign full       = (count_reg == CW'(DEPTH));
   assign req        = MemWriteM & size_ok & ~mis;
   assign enq        = req & ~full;
   assign deq        = DMemWE & DMemReady;
   assign StallStore = req & full;

   assign DMemWE  = (count_reg != '0);
   assign SBEmpty = (count_reg == '0);

   // Head fields are gated so the port reads all-zero whenever the buffer is empty.
   assign DMemAddr  = DMemWE ? addr_mem[rd_ptr_reg] : '0;
   assign DMemWData = DMemWE ? data_mem[rd_ptr_reg] : '0;
   assign DMemBE    = DMemWE ? be_mem[rd_ptr_reg]   : '0;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (enq && (wr_ptr_reg == PW'(gi))) begin
               addr_mem[gi] <= {ALUResultM[AW-1:2], 2'b00};
               data_mem[gi] <= fmt_data;
               be_mem[gi]   <= fmt_be;
            end
         end
      end
   endgenerate

   always_comb begin
      count_next = count_reg;
      case ({enq, deq})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (deq) rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_next;
      end
   end

endmodule

// File: tb/tb_rv32i_storeunit.sv
// Scoreboard bench for rv32i_storeunit: directed scenarios then randomized stores
// with random DMemReady back-pressure, checked against a queue-based reference model.
module tb_rv32i_storeunit;
   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          MemWriteM = 1'b0;
   logic [2:0]    StoreSizeM = 3'b000;
   logic [AW-1:0] ALUResultM = '0;
   logic [31:0]   WriteDataM = '0;
   logic          DMemReady = 1'b0;
   logic          StallStore, SBEmpty, DMemWE;
   logic [AW-1:0] DMemAddr;
   logic [31:0]   DMemWData;
   logic [3:0]    DMemBE;
`ifdef MISALIGN_TRAP_EN
   logic          MisalignedM;
`endif

   rv32i_storeunit #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .StoreSizeM(StoreSizeM),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .StallStore(StallStore),
      .SBEmpty(SBEmpty),
`ifdef MISALIGN_TRAP_EN
      .MisalignedM(MisalignedM),
`endif
      .DMemWE(DMemWE), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
      .DMemBE(DMemBE), .DMemReady(DMemReady)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   wr_t model_q[$];
   wr_t sb_q[$];
   bit  acc_last;
   int  checks = 0;
   int  errors = 0;
   int  writes = 0;

   function automatic bit ref_valid(input logic [2:0] sz);
      return sz <= 3'd2;
   endfunction

   function automatic bit ref_mis(input logic [2:0] sz, input logic [31:0] ad);
`ifdef MISALIGN_TRAP_EN
      return (sz == 3'd1 && ad[0]) || (sz == 3'd2 && ad[1:0] != 2'b00);
`else
      return (sz == 3'd7) && (ad == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   // Byte-lane view: an nbytes-wide store lands at lane base, data repeats across the word.
   function automatic wr_t ref_fmt(input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
      wr_t r;
      int nbytes, base, off;
      off    = int'(ad[1:0]);
      nbytes = 1 << int'(sz);
      if (sz == 3'd0)      base = off;
      else if (sz == 3'd1) base = (off >= 2) ? 2 : 0;
      else                 base = 0;
      r.addr = ad - 32'(off);
      r.be   = '0;
      for (int i = 0; i < 4; i++) r.data[8*i +: 8] = wd[8*(i % nbytes) +: 8];
      for (int i = 0; i < nbytes; i++) r.be[base + i] = 1'b1;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks buffer occupancy and pushes expected writes on enqueue.
   always @(posedge clk or posedge rst) begin
      bit deq, enq;
      if (rst) begin
         model_q.delete();
         sb_q.delete();
         acc_last = 1'b0;
      end else begin
         deq = (model_q.size() != 0) && DMemReady;
         enq = MemWriteM && ref_valid(StoreSizeM) && !ref_mis(StoreSizeM, ALUResultM)
               && (model_q.size() < DEPTH);
         acc_last = enq;
         if (deq) void'(model_q.pop_front());
         if (enq) begin
            model_q.push_back(ref_fmt(StoreSizeM, ALUResultM, WriteDataM));
            sb_q.push_back(ref_fmt(StoreSizeM, ALUResultM, WriteDataM));
         end
      end
   end

   // Monitor: samples mid-cycle, checks status and pops the scoreboard on each accepted write.
   always @(negedge clk) begin
      wr_t h;
      bit  es;
      #1;
      if (!rst) begin
         check("dmemwe", DMemWE, model_q.size() != 0);
         check("sbempty", SBEmpty, model_q.size() == 0);
         es = MemWriteM && ref_valid(StoreSizeM) && !ref_mis(StoreSizeM, ALUResultM)
              && (model_q.size() == DEPTH);
         check("stall", StallStore, es);
`ifdef MISALIGN_TRAP_EN
         check("misaligned", MisalignedM, MemWriteM && ref_mis(StoreSizeM, ALUResultM));
`endif
         if (DMemWE) begin
            if (sb_q.size() == 0) begin
               check("unexpected_write", DMemWE, 1'b0);
            end else begin
               h = sb_q[0];
               check("wr_addr", DMemAddr, h.addr);
               check("wr_data", DMemWData, h.data);
               check("wr_be", DMemBE, h.be);
               if (DMemReady) begin
                  void'(sb_q.pop_front());
                  writes++;
               end
            end
         end
      end
   end

   task automatic store(input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
      bit ok = 1'b0;
      MemWriteM  = 1'b1;
      StoreSizeM = sz;
      ALUResultM = ad;
      WriteDataM = wd;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = acc_last;
      end
      check("store_accept", ok, 1'b1);
      MemWriteM = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, bias;
      bit ok;
      #2;
      check("rst_stall", StallStore, 1'b0);
      check("rst_sbempty", SBEmpty, 1'b1);
      check("rst_we", DMemWE, 1'b0);
      check("rst_addr", DMemAddr, 32'h0);
      check("rst_wdata", DMemWData, 32'h0);
      check("rst_be", DMemBE, 4'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      DMemReady = 1'b1;

      store(3'd2, 32'h104, 32'hDEADBEEF);
      #1;
      check("sw_addr", DMemAddr, 32'h104);
      check("sw_data", DMemWData, 32'hDEADBEEF);
      check("sw_be", DMemBE, 4'b1111);
      @(negedge clk); #1;
      check("sw_empty_after", SBEmpty, 1'b1);

      store(3'd0, 32'h203, 32'h000000A5);
      #1;
      check("sb_addr", DMemAddr, 32'h200);
      check("sb_data", DMemWData, 32'hA5A5A5A5);
      check("sb_be", DMemBE, 4'b1000);
      @(negedge clk);

      store(3'd1, 32'h202, 32'h00001234);
      #1;
      check("sh_data", DMemWData, 32'h12341234);
      check("sh_be", DMemBE, 4'b1100);
      @(negedge clk);

`ifdef MISALIGN_TRAP_EN
      MemWriteM = 1'b1; StoreSizeM = 3'd2; ALUResultM = 32'h101; WriteDataM = 32'h55AA;
      #1;
      check("mis_flag", MisalignedM, 1'b1);
      check("mis_nostall", StallStore, 1'b0);
      @(negedge clk);
      MemWriteM = 1'b0;
      #1;
      check("mis_no_we", DMemWE, 1'b0);
`else
      store(3'd2, 32'h101, 32'h55AA);
      #1;
      check("misw_addr", DMemAddr, 32'h100);
      check("misw_be", DMemBE, 4'b1111);
`endif
      @(negedge clk);

      MemWriteM = 1'b1; StoreSizeM = 3'd3; ALUResultM = 32'h400; WriteDataM = 32'h1;
      @(negedge clk);
      MemWriteM = 1'b0;
      #1;
      check("invalid_no_we", DMemWE, 1'b0);
      @(negedge clk);

      // Fill with back-pressure, then release and confirm the fifth store is taken in order.
      DMemReady = 1'b0;
      w0 = writes;
      for (int i = 0; i < 4; i++) store(3'd2, 32'h300 + 32'(4*i), 32'h1000 + 32'(i));
      MemWriteM = 1'b1; StoreSizeM = 3'd2; ALUResultM = 32'h310; WriteDataM = 32'h1004;
      #1;
      check("fifth_stall", StallStore, 1'b1);
      @(negedge clk);
      DMemReady = 1'b1;
      #1;
      check("full_ready_stall", StallStore, 1'b1);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = acc_last;
      end
      check("fifth_accept", ok, 1'b1);
      MemWriteM = 1'b0;
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      @(negedge clk); #2;
      check("five_written", writes - w0, 5);

      DMemReady = 1'b0;
      for (int i = 0; i < 3; i++) store(3'd0, 32'h500 + 32'(i), 32'hC0 + 32'(i));
      rst = 1'b1;
      #1;
      check("midrst_we", DMemWE, 1'b0);
      check("midrst_sbempty", SBEmpty, 1'b1);
      check("midrst_addr", DMemAddr, 32'h0);
      w0 = writes;
      @(negedge clk);
      rst = 1'b0;
      DMemReady = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      check("midrst_no_writes", writes - w0, 0);

      bias = 8;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r;
         @(negedge clk);
         if (cyc % 200 == 0) bias = $urandom_range(1, 8);
         DMemReady = ($urandom_range(0, 7) < bias);
         if (!(MemWriteM && ref_valid(StoreSizeM) && !ref_mis(StoreSizeM, ALUResultM) && !acc_last)) begin
            r = $urandom_range(0, 9);
            MemWriteM  = ($urandom_range(0, 3) != 0);
            StoreSizeM = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
            ALUResultM = $urandom;
            WriteDataM = $urandom;
         end
      end

      MemWriteM = 1'b0;
      DMemReady = 1'b1;
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
      @(negedge clk); #2;
      check("final_drained", sb_q.size(), 0);
      check("final_we", DMemWE, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
